// File: rtl/ppu_wb_packer.sv
// rtl/ppu_wb_packer.sv - PPU write-back byte packer with word FIFO and global-buffer write port
//
// Collects the post-processing unit's 8-bit activation stream, packs four
// bytes little-endian into a 32-bit word, queues words in a small FIFO and
// writes them to the global buffer at incrementing word addresses.
//
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   i_start, i_base_addr  start pulse and first output word address
//   i_byte_valid, i_byte, i_last   PPU activation stream (no stall)
//   o_wr_en, o_wr_addr, o_wr_data, o_wr_strb, i_wr_ready   buffer write port
//   o_busy                high while running or draining
//   o_done                one-cycle pulse when the tile's last word is written
//   o_overflow            sticky: a packed word was dropped on a full FIFO

module ppu_wb_packer #(
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_BITS  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_start,
  input  logic [ADDR_BITS-1:0] i_base_addr,
  input  logic                 i_byte_valid,
  input  logic [7:0]           i_byte,
  input  logic                 i_last,
  output logic                 o_wr_en,
  output logic [ADDR_BITS-1:0] o_wr_addr,
  output logic [31:0]          o_wr_data,
  output logic [3:0]           o_wr_strb,
  input  logic                 i_wr_ready,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_overflow
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t               state;
  logic [1:0]           byte_cnt;
  logic [23:0]          pack_reg;
  logic [31:0]          fifo_data [FIFO_DEPTH];
  logic [3:0]           fifo_strb [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr;
  logic [PTR_W-1:0]     rd_ptr;
  logic [CNT_W-1:0]     count;
  logic [CNT_W-1:0]     count_next;
  logic [ADDR_BITS-1:0] addr;
  logic                 overflow;
  logic                 done;

  logic                 fifo_empty;
  logic                 fifo_full;
  logic                 byte_acc;
  logic                 word_done;
  logic                 pop;
  logic                 push;
  logic                 drop;
  logic [23:0]          pack_next;
  logic [31:0]          new_word;
  logic [3:0]           new_strb;

  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == CNT_W'(FIFO_DEPTH));

  // i_start wins over any coincident byte or write handshake.
  assign byte_acc  = !i_start && (state == RUN) && i_byte_valid;
  assign word_done = byte_acc && ((byte_cnt == 2'd3) || i_last);
  assign pop       = !i_start && !fifo_empty && i_wr_ready;
  // A pop in the same cycle frees the head slot, so a full FIFO can still accept.
  assign push      = word_done && (!fifo_full || pop);
  assign drop      = word_done && fifo_full && !pop;

  // pack_reg lanes above byte_cnt are always zero, so partial words come out
  // with unused lanes cleared without extra masking.
  always_comb begin
    pack_next = pack_reg;
    new_strb  = 4'b1111;
    case (byte_cnt)
      2'd0: begin pack_next[7:0]   = i_byte; new_strb = 4'b0001; end
      2'd1: begin pack_next[15:8]  = i_byte; new_strb = 4'b0011; end
      2'd2: begin pack_next[23:16] = i_byte; new_strb = 4'b0111; end
      default: begin new_strb = 4'b1111; end
    endcase
    new_word = (byte_cnt == 2'd3) ? {i_byte, pack_reg} : {8'h00, pack_next};
  end

  always_comb begin
    count_next = count;
    case ({push, pop})
      2'b10:   count_next = count + CNT_W'(1);
      2'b01:   count_next = count - CNT_W'(1);
      default: count_next = count;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      byte_cnt <= 2'd0;
      pack_reg <= 24'h0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      addr     <= '0;
      overflow <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (i_start) begin
        state    <= RUN;
        addr     <= i_base_addr;
        byte_cnt <= 2'd0;
        pack_reg <= 24'h0;
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        count    <= '0;
        overflow <= 1'b0;
      end else begin
        if (pop) begin
          rd_ptr <= rd_ptr + PTR_W'(1);
          addr   <= addr + ADDR_BITS'(1);
        end
        if (push) begin
          wr_ptr <= wr_ptr + PTR_W'(1);
        end
        count <= count_next;
        if (drop) begin
          overflow <= 1'b1;
        end
        if (byte_acc) begin
          if (word_done) begin
            byte_cnt <= 2'd0;
            pack_reg <= 24'h0;
          end else begin
            byte_cnt <= byte_cnt + 2'd1;
            pack_reg <= pack_next;
          end
        end
        case (state)
          RUN: begin
            // A dropped last word still ends the tile.
            if (byte_acc && i_last) begin
              state <= DRAIN;
            end
          end
          DRAIN: begin
            if (count_next == '0) begin
              state <= IDLE;
              done  <= 1'b1;
            end
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

  // Storage only; validity is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data[wr_ptr] <= new_word;
      fifo_strb[wr_ptr] <= new_strb;
    end
  end

  assign o_wr_en    = !fifo_empty;
  assign o_wr_addr  = addr;
  assign o_wr_data  = fifo_empty ? 32'h0 : fifo_data[rd_ptr];
  assign o_wr_strb  = fifo_empty ? 4'h0 : fifo_strb[rd_ptr];
  assign o_busy     = (state != IDLE);
  assign o_done     = done;
  assign o_overflow = overflow;

endmodule
